// File: rtl/csd_to_bin.sv
// Serial CSD-to-two's-complement decoder; one digit per cycle, MSB first, via a shift-and-add accumulator.
// Latency N+2 cycles from the start edge to the done pulse; start is ignored while a word is in flight.
module csd_to_bin #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2*N-1:0]      csdIn,
  output logic                busy,
  output logic                done,
  output logic signed [N:0]   dataOut,
  output logic [CNT_W-1:0]    nzCount,
  output logic                errCode,
  output logic                errCanon
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state;
  logic [2*N-1:0]      shiftReg;
  logic signed [N:0]   acc;
  logic [CNT_W-1:0]    idx;
  logic [CNT_W-1:0]    cnt;
  logic                prevNz;
  logic                codeErr;
  logic                canonErr;

  logic [1:0]          topCode;
  logic                digitNz;
  logic                digitInv;
  logic signed [N:0]   digitVal;

  // The word is shifted left so the digit being processed is always the top pair.
  always_comb begin
    topCode  = shiftReg[2*N-1 -: 2];
    digitNz  = 1'b0;
    digitInv = 1'b0;
    digitVal = '0;
    case (topCode)
      2'b01: begin
        digitNz  = 1'b1;
        digitVal = (N+1)'(1);
      end
      2'b11: begin
        digitNz  = 1'b1;
        digitVal = '1;
      end
      2'b10:   digitInv = 1'b1;
      default: digitVal = '0;
    endcase
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shiftReg <= '0;
      acc      <= '0;
      idx      <= '0;
      cnt      <= '0;
      prevNz   <= 1'b0;
      codeErr  <= 1'b0;
      canonErr <= 1'b0;
      done     <= 1'b0;
      dataOut  <= '0;
      nzCount  <= '0;
      errCode  <= 1'b0;
      errCanon <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shiftReg <= csdIn;
            acc      <= '0;
            cnt      <= '0;
            prevNz   <= 1'b0;
            codeErr  <= 1'b0;
            canonErr <= 1'b0;
            errCode  <= 1'b0;
            errCanon <= 1'b0;
            idx      <= CNT_W'(N-1);
            state    <= RUN;
          end
        end
        RUN: begin
          // Magnitude never exceeds 2^N-1, so N+1 signed bits cannot overflow.
          acc      <= (acc <<< 1) + digitVal;
          shiftReg <= shiftReg << 2;
          if (digitNz)           cnt      <= cnt + CNT_W'(1);
          if (digitInv)          codeErr  <= 1'b1;
          if (digitNz && prevNz) canonErr <= 1'b1;
          prevNz <= digitNz;
          if (idx == '0) state <= DONE;
          else           idx   <= idx - CNT_W'(1);
        end
        DONE: begin
          done     <= 1'b1;
          dataOut  <= acc;
          nzCount  <= cnt;
          errCode  <= codeErr;
          errCanon <= canonErr;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csd_to_bin.sv
// Scoreboard bench for csd_to_bin: expected results queued at start, compared on each done pulse.
module tb_csd_to_bin;

  localparam int N     = 8;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic signed [N:0]  data;
    logic [CNT_W-1:0]   nz;
    logic               ec;
    logic               cn;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [2*N-1:0]     csdIn;
  logic               busy;
  logic               done;
  logic signed [N:0]  dataOut;
  logic [CNT_W-1:0]   nzCount;
  logic               errCode;
  logic               errCanon;

  int   compared   = 0;
  int   mismatched = 0;
  exp_t expQ[$];
  exp_t monExp;
  int   cyc;
  int   busyCnt;

  csd_to_bin #(.N(N), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .csdIn    (csdIn),
    .busy     (busy),
    .done     (done),
    .dataOut  (dataOut),
    .nzCount  (nzCount),
    .errCode  (errCode),
    .errCanon (errCanon)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic exp_t mkExp(input int data, input int nz, input bit ec, input bit cn);
    exp_t e;
    e.data = (N+1)'(data);
    e.nz   = CNT_W'(nz);
    e.ec   = ec;
    e.cn   = cn;
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (expQ.size() == 0) begin
        checkVal("spurious_done", 32'd1, 32'd0);
      end else begin
        monExp = expQ.pop_front();
        checkVal("dataOut",  32'(dataOut),  32'(monExp.data));
        checkVal("nzCount",  32'(nzCount),  32'(monExp.nz));
        checkVal("errCode",  32'(errCode),  32'(monExp.ec));
        checkVal("errCanon", 32'(errCanon), 32'(monExp.cn));
      end
    end
  end

  // Returns at the first negedge after the start edge (cycle 1).
  task automatic sendWord(input logic [2*N-1:0] w, input exp_t e, input bit push);
    @(negedge clk);
    csdIn = w;
    start = 1'b1;
    if (push) expQ.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycle k is the one following the k-th edge after the start edge.
  task automatic waitDone(input bit noisy, output int cycles, output int busyCycles);
    cycles = 1;
    busyCycles = 0;
    while (!done && cycles < 40) begin
      if (busy) busyCycles++;
      if (noisy) begin
        case (cycles)
          1: begin start = 1'b1; csdIn = 16'h00C1; end
          2: start = 1'b0;
          4: begin start = 1'b1; csdIn = 16'h4444; end
          5: start = 1'b0;
          default: ;
        endcase
      end
      @(negedge clk);
      cycles++;
    end
    if (!done) checkVal("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    csdIn = '0;
    repeat (2) @(negedge clk);
    checkVal("rst_busy",     32'(busy),     32'd0);
    checkVal("rst_done",     32'(done),     32'd0);
    checkVal("rst_dataOut",  32'(dataOut),  32'd0);
    checkVal("rst_nzCount",  32'(nzCount),  32'd0);
    checkVal("rst_errCode",  32'(errCode),  32'd0);
    checkVal("rst_errCanon", 32'(errCanon), 32'd0);
    reset = 1'b1;

    sendWord(16'h0000, mkExp(0, 0, 0, 0), 1'b1);
    waitDone(1'b0, cyc, busyCnt);
    checkVal("latency_zero", 32'(cyc), 32'(N + 2));

    sendWord(16'h0043, mkExp(7, 2, 0, 0), 1'b1);
    waitDone(1'b0, cyc, busyCnt);
    checkVal("latency_p7", 32'(cyc), 32'(N + 2));
    checkVal("busy_cycles_p7", 32'(busyCnt), 32'(N));

    sendWord(16'h00C1, mkExp(-7, 2, 0, 0), 1'b1);
    waitDone(1'b0, cyc, busyCnt);
    sendWord(16'h4444, mkExp(170, 4, 0, 0), 1'b1);
    waitDone(1'b0, cyc, busyCnt);
    sendWord(16'hCCCC, mkExp(-170, 4, 0, 0), 1'b1);
    waitDone(1'b0, cyc, busyCnt);
    sendWord(16'h0005, mkExp(3, 2, 0, 1), 1'b1);
    waitDone(1'b0, cyc, busyCnt);

    // errCanon from the previous word must be cleared as soon as the next start is accepted.
    sendWord(16'h0020, mkExp(0, 0, 1, 0), 1'b1);
    checkVal("errCanon_cleared_on_start", 32'(errCanon), 32'd0);
    checkVal("dataOut_held_in_run", 32'(dataOut), 32'd3);
    waitDone(1'b0, cyc, busyCnt);

    // Re-asserted starts during RUN must not disturb the word in flight.
    sendWord(16'h0043, mkExp(7, 2, 0, 0), 1'b1);
    waitDone(1'b1, cyc, busyCnt);
    checkVal("latency_noisy", 32'(cyc), 32'(N + 2));
    checkVal("busy_cycles_noisy", 32'(busyCnt), 32'(N));
    repeat (N + 4) @(negedge clk);

    // Abort a word in RUN cycle 4: outputs clear at once and no done follows.
    sendWord(16'h4444, mkExp(0, 0, 0, 0), 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkVal("abort_busy",    32'(busy),    32'd0);
    checkVal("abort_dataOut", 32'(dataOut), 32'd0);
    checkVal("abort_nzCount", 32'(nzCount), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2 * N) @(negedge clk);

    sendWord(16'hCCCC, mkExp(-170, 4, 0, 0), 1'b1);
    waitDone(1'b0, cyc, busyCnt);
    checkVal("latency_after_abort", 32'(cyc), 32'(N + 2));
    repeat (4) @(negedge clk);
    checkVal("queue_drained", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
